routine_bus_sink: RTL
=====================

# routine_bus_sink

Consumer end of the 47-bit light-routine output bus. It captures each frame the active routine publishes: 18 LED bits, four active-low GFEDCBA 7-segment patterns and a frame strobe on bit 46. It drives the physical board pins by time-multiplexing the four digits onto one shared segment bus. It also decodes the captured segment patterns back into hex nibbles for readback and self-check, and blanks the board when the routine stops publishing.

## Interface
- SCAN_DIV, 1024: clock cycles per digit slot (≥ BLANK+1, ≤ 65535)
- BLANK, 16: cycles at the start of each slot with all anodes off (anti-ghosting)
- STALE_CYCLES, 1048576: cycles without a strobe before the outputs blank (< 2^24)
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low; clears all state immediately
- RoutineBus  in  47  [46] frame strobe (1-cycle pulse); [45:28] LEDs; [27:21] digit 3, [20:14] digit 2, [13:7] digit 1, [6:0] digit 0; segments active-low, GFEDCBA order per digit
- Leds  out  18  LED pins, active-high, registered
- Seg  out  7  shared segment pins, active-low GFEDCBA, registered
- Anode  out  4  digit enables, active-low, one-hot or all-off, registered
- DigitValue  out  16  decoded nibbles, [4k+3:4k] = digit k
- DigitValid  out  4  bit k = digit k pattern is a legal hex glyph
- FrameCount  out  16  strobes accepted since reset, wraps
- Stale  out  1  no strobe within STALE_CYCLES, or none since reset

## Operation
- Capture: when RoutineBus[46]=1 at an edge, LedReg←[45:28] and SegReg←[27:0] (kept active-low). FrameCount increments, wrapping FFFF→0000. StaleCnt←0 and Stale←0 on the same edge. Bits [45:0] are ignored when the strobe is low.
- A strobe held high for n cycles counts as n frames. The last captured data wins.
- Stale: StaleCnt is 24-bit and saturates. When it reaches STALE_CYCLES, Stale←1. A strobe on that same edge wins: Stale stays 0.
- Leds output: LedReg, or 0 while Stale=1.
- Scan: ScanCnt runs 0..SCAN_DIV-1. At the terminal count it returns to 0 and Digit advances 0→1→2→3→0. The scan is free-running and ignores strobes and Stale.
- Anode register: 4'hF if Stale or ScanCnt<BLANK; otherwise ~(1<<Digit).
- Seg register: 7'h7F if Stale or ScanCnt<BLANK; otherwise SegReg[7·Digit+6 : 7·Digit].
- Decode: each SegReg digit is inverted to active-high and matched against the glyph set 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Match: nibble = glyph index, valid = 1.
  - No match (including blank 00): nibble = 0, valid = 0.
  - Result is registered into DigitValue/DigitValid and is independent of Stale.
- A new capture mid-slot changes Seg on the next edge. Tearing within a slot is accepted.

## Timing
- Reset values: Leds 0, Seg 7'h7F, Anode 4'hF, DigitValue 0, DigitValid 0, FrameCount 0, Stale 1. Internal reset values: LedReg 0, SegReg all 1, ScanCnt 0, Digit 0, StaleCnt 0.
- Deasserting Reset mid-scan or mid-frame discards all captured data. No partial frame survives.
- Strobe sampled at edge N:
  - LedReg/SegReg, FrameCount and Stale update at N.
  - Leds, Seg and Anode reflect the new data at N+1.
  - DigitValue/DigitValid update at N+1.
- Slot timing: each digit is enabled for SCAN_DIV−BLANK cycles, with a period of 4·SCAN_DIV per digit. Anode/Seg lag ScanCnt/Digit by one register stage.
- Stale asserts at the edge where the STALE_CYCLES-th consecutive strobe-free cycle completes. Blanking takes effect one edge later.

## Test plan
Bench parameters: SCAN_DIV=8, BLANK=2, STALE_CYCLES=64.
- Reset release, no strobe for 100 cycles -> Stale=1 throughout; Seg=7F, Anode=F, Leds=0, FrameCount=0.
- One strobe with LEDs=3FFFF, digits 3..0 = ~06,~5B,~4F,~66 -> Leds=3FFFF at N+1; DigitValue=1234, DigitValid=F at N+1; scan shows Anode=E with Seg=~66 for 6 cycles after 2 blank cycles, then D/~4F, B/~5B, 7/~06.
- Digit 2 pattern = all-1 (blank) and digit 0 = ~00 (segments all on, active-high 7F = 8) -> DigitValid=1011 (bits 3..0), DigitValue[11:8]=0, DigitValue[3:0]=8.
- Strobe, then 64 idle cycles -> Stale rises at the 64th; Seg/Anode/Leds blank next edge. Next strobe -> Stale=0 at that edge and display resumes with no Digit reset.
- 65537 single-cycle strobes -> FrameCount=0001. Strobe coinciding with StaleCnt=64 -> Stale stays 0.
- Reset asserted mid-slot with Anode=B -> Anode=F and Seg=7F asynchronously. After release, the first enabled slot is digit 0 and displays blank until the next strobe.

Source files
------------

// File: rtl/routine_bus_sink.sv
// Consumer end of the 47-bit light-routine bus: captures strobed frames, scans the
// four 7-segment digits onto shared pins, decodes glyphs back to hex, blanks when stale.
module routine_bus_sink #(
    parameter int SCAN_DIV     = 1024,
    parameter int BLANK        = 16,
    parameter int STALE_CYCLES = 1048576
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [46:0] routine_bus_i,
    output logic [17:0] leds_o,
    output logic [6:0]  seg_o,
    output logic [3:0]  anode_o,
    output logic [15:0] digit_value_o,
    output logic [3:0]  digit_valid_o,
    output logic [15:0] frame_count_o,
    output logic        stale_o
);

    logic        strobe;
    logic [17:0] led_q, led_d;
    logic [27:0] seg_q, seg_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [23:0] stale_cnt_q, stale_cnt_d;
    logic        stale_q, stale_d;
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [17:0] leds_out_q, leds_out_d;
    logic [6:0]  seg_out_q, seg_out_d;
    logic [3:0]  anode_q, anode_d;
    logic [15:0] dval_q, dval_d;
    logic [3:0]  dvalid_q, dvalid_d;
    logic [4:0]  glyph;
    logic        blank_slot;

    assign strobe = routine_bus_i[46];

    // Returns {valid, nibble} for one active-low GFEDCBA pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg_n);
        logic [6:0] s;
        s = ~seg_n;
        case (s)
            7'h3F:   decode_glyph = 5'h10;
            7'h06:   decode_glyph = 5'h11;
            7'h5B:   decode_glyph = 5'h12;
            7'h4F:   decode_glyph = 5'h13;
            7'h66:   decode_glyph = 5'h14;
            7'h6D:   decode_glyph = 5'h15;
            7'h7D:   decode_glyph = 5'h16;
            7'h07:   decode_glyph = 5'h17;
            7'h7F:   decode_glyph = 5'h18;
            7'h6F:   decode_glyph = 5'h19;
            7'h77:   decode_glyph = 5'h1A;
            7'h7C:   decode_glyph = 5'h1B;
            7'h39:   decode_glyph = 5'h1C;
            7'h5E:   decode_glyph = 5'h1D;
            7'h79:   decode_glyph = 5'h1E;
            7'h71:   decode_glyph = 5'h1F;
            default: decode_glyph = 5'h00;
        endcase
    endfunction

    always_comb begin
        led_d       = led_q;
        seg_d       = seg_q;
        frame_cnt_d = frame_cnt_q;
        stale_cnt_d = stale_cnt_q;
        stale_d     = stale_q;
        if (strobe) begin
            led_d       = routine_bus_i[45:28];
            seg_d       = routine_bus_i[27:0];
            frame_cnt_d = frame_cnt_q + 16'd1;
            stale_cnt_d = '0;
            stale_d     = 1'b0;
        end else begin
            if (stale_cnt_q != 24'hFFFFFF) begin
                stale_cnt_d = stale_cnt_q + 24'd1;
            end
            // Sticky until the next strobe; also holds after reset until one arrives.
            if (stale_cnt_d >= 24'(STALE_CYCLES)) begin
                stale_d = 1'b1;
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 16'd1;
        digit_d    = digit_q;
        if (scan_cnt_q == 16'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
    end

    // Display stage works from the registered scan position, so pins lag by one edge.
    always_comb begin
        blank_slot = stale_q || (scan_cnt_q < 16'(BLANK));
        leds_out_d = stale_q ? 18'd0 : led_q;
        anode_d    = 4'hF;
        seg_out_d  = 7'h7F;
        if (!blank_slot) begin
            anode_d   = ~(4'b0001 << digit_q);
            seg_out_d = seg_q[7*digit_q +: 7];
        end
    end

    always_comb begin
        dval_d   = '0;
        dvalid_d = '0;
        glyph    = '0;
        for (int k = 0; k < 4; k++) begin
            glyph            = decode_glyph(seg_q[7*k +: 7]);
            dval_d[4*k +: 4] = glyph[3:0];
            dvalid_d[k]      = glyph[4];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q       <= '0;
            seg_q       <= '1;
            frame_cnt_q <= '0;
            stale_cnt_q <= '0;
            stale_q     <= 1'b1;
            scan_cnt_q  <= '0;
            digit_q     <= '0;
            leds_out_q  <= '0;
            seg_out_q   <= 7'h7F;
            anode_q     <= 4'hF;
            dval_q      <= '0;
            dvalid_q    <= '0;
        end else begin
            led_q       <= led_d;
            seg_q       <= seg_d;
            frame_cnt_q <= frame_cnt_d;
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= stale_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            leds_out_q  <= leds_out_d;
            seg_out_q   <= seg_out_d;
            anode_q     <= anode_d;
            dval_q      <= dval_d;
            dvalid_q    <= dvalid_d;
        end
    end

    assign leds_o        = leds_out_q;
    assign seg_o         = seg_out_q;
    assign anode_o       = anode_q;
    assign digit_value_o = dval_q;
    assign digit_valid_o = dvalid_q;
    assign frame_count_o = frame_cnt_q;
    assign stale_o       = stale_q;

endmodule
